// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP add/sub operand sequencer.
package fp_seq_pkg;

    localparam int   FP_W     = 32;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/fp_addsub_sequencer.sv
// Feeds operand pairs from a vector memory into the FP add/sub unit and
// streams each captured result out over a valid/ready port.
module fp_addsub_sequencer
    import fp_seq_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_count,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [FP_W-1:0]   i_rd_data_a,
    input  logic [FP_W-1:0]   i_rd_data_b,
    output logic [FP_W-1:0]   o_operand_a,
    output logic [FP_W-1:0]   o_operand_b,
    output logic              o_add_sub_signal,
    input  logic [FP_W-1:0]   i_operand_o,
    input  logic              i_exception,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [FP_W-1:0]   o_res_data,
    output logic              o_res_exc,
    output logic [ADDR_W-1:0] o_res_index,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_exc_count,
    output state_t            o_state
);

    // Result handshake: a result transfers on any rising edge where
    // o_res_valid and i_res_ready are both high; while valid is high and
    // ready is low, data, exception flag and index are held unchanged.

    localparam int WCNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] count;
    logic              mode;
    logic [WCNT_W-1:0] wait_cnt;
    logic              last;
    logic              wait_end;

    assign last     = (index == count - ADDR_W'(1));
    assign wait_end = (wait_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (i_start) state_next = (i_count == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_WAIT;
            S_WAIT:  if (wait_end) state_next = S_EMIT;
            S_EMIT:  if (i_res_ready) state_next = last ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers; the wait counter covers the adder's pipeline depth
    // plus the edge on which the result is captured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            index            <= '0;
            count            <= '0;
            mode             <= MODE_ADD;
            wait_cnt         <= '0;
            o_operand_a      <= '0;
            o_operand_b      <= '0;
            o_add_sub_signal <= 1'b0;
            o_res_data       <= '0;
            o_res_exc        <= 1'b0;
            o_res_index      <= '0;
            o_exc_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mode        <= i_mode;
                        count       <= i_count;
                        index       <= '0;
                        o_exc_count <= '0;
                    end
                end
                S_LOAD: begin
                    o_operand_a      <= i_rd_data_a;
                    o_operand_b      <= i_rd_data_b;
                    o_add_sub_signal <= mode;
                    wait_cnt         <= WCNT_W'(LAT);
                end
                S_WAIT: begin
                    if (wait_end) begin
                        o_res_data  <= i_operand_o;
                        o_res_exc   <= i_exception;
                        o_res_index <= index;
                        if (i_exception && (o_exc_count != '1)) begin
                            o_exc_count <= o_exc_count + ADDR_W'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WCNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (i_res_ready && !last) begin
                        index <= index + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_DONE);
        o_res_valid = (state == S_EMIT);
        o_rd_addr   = index;
        o_state     = state;
    end

endmodule

// File: doc/fp_addsub_sequencer.md
Name: fp_addsub_sequencer

Overview:
- Drives the Addition_Subtraction unit from the other side of its operand interface.
- Fetches operand pairs from an external dual-output vector memory and presents them to the adder's i_operand_a/i_operand_b/add_sub_signal inputs.
- Captures o_operand_o/o_exception from the adder and streams each result out over a valid/ready port.
- Used for on-chip self-test and batch execution of the FP add/sub datapath.

Parameters:
- ADDR_W, 6: vector memory address width; maximum run length is 2^ADDR_W - 1.
- LAT, 2: number of register stages in the attached adder (0 = combinational).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  run request; sampled only in IDLE.
- i_mode  in  1  0 = add, 1 = subtract; latched on accepted start.
- i_count  in  ADDR_W  number of operand pairs; latched on accepted start.
- o_rd_addr  out  ADDR_W  vector memory address.
- i_rd_data_a  in  32  operand A word; valid one cycle after o_rd_addr.
- i_rd_data_b  in  32  operand B word; valid one cycle after o_rd_addr.
- o_operand_a  out  32  to adder i_operand_a (registered).
- o_operand_b  out  32  to adder i_operand_b (registered).
- o_add_sub_signal  out  1  to adder add_sub_signal (registered).
- i_operand_o  in  32  adder result.
- i_exception  in  1  adder exception flag.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  result consumer ready.
- o_res_data  out  32  captured result.
- o_res_exc  out  1  captured exception.
- o_res_index  out  ADDR_W  vector index of the presented result.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at end of run.
- o_exc_count  out  ADDR_W  exceptions seen in the current or last run; cleared on accepted start.

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs go to 0 and the state goes to IDLE.
  - Assertion mid-run aborts the run; no o_done is produced.
- FSM states: IDLE, FETCH, LOAD, WAIT, EMIT, DONE.
- IDLE:
  - On i_start=1: latch i_mode and i_count, set index to 0, clear o_exc_count.
  - If i_count==0, go to DONE; otherwise go to FETCH.
- FETCH: drive o_rd_addr=index for one cycle, then go to LOAD.
- LOAD: register i_rd_data_a/b into o_operand_a/b and latched mode into o_add_sub_signal, then go to WAIT.
- WAIT:
  - Lasts exactly LAT+1 cycles; the down-counter is loaded with LAT on entry.
  - On the final edge, capture i_operand_o into o_res_data, i_exception into o_res_exc, and index into o_res_index.
  - On the same edge, increment o_exc_count if i_exception=1, saturating at all ones. Then go to EMIT.
- Operand outputs are held stable from the LOAD edge until the next LOAD.
- EMIT:
  - o_res_valid=1; data/exc/index are stable while valid and not ready.
  - On the valid&&ready edge: if index==count-1, go to DONE; otherwise index++ and go to FETCH.
  - o_res_valid deasserts on that edge.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Latency: o_res_valid rises LAT+3 edges after the start-accept edge, which is 5 for LAT=2.
- Per-vector period with ready tied high: LAT+4 cycles.
- i_start while busy: ignored and not queued.
- i_start in the same cycle as DONE: ignored; a new start is accepted only in IDLE.
- i_mode/i_count changes during a run: no effect.
- The sequencer does no arithmetic on data; results pass bit-exact.

Decomposition:
- Shared package fp_seq_pkg holds:
  - the state enum;
  - constants MODE_ADD=0 and MODE_SUB=1;
  - the FP word width 32.
- No sub-module; a single FSM with counters is sufficient.
- A top-level wrapper instantiating this block with Addition_Subtraction is a separate file.

Test Plan:
- Add run: mem[0]=3F800000/40000000, mem[1]=40400000/3F800000, i_mode=0, i_count=2, ready=1 -> results 40400000 (idx0) then 40800000 (idx1), o_res_exc=0, one o_done pulse, first valid 5 cycles after start.
- Subtract run: same memory, i_mode=1 -> o_add_sub_signal=1, results BF800000 (idx0) then 40000000 (idx1).
- Backpressure: hold i_res_ready=0 for 7 cycles during EMIT -> o_res_valid, o_res_data and o_res_index stay constant, o_rd_addr does not advance, and exactly one result transfers when ready rises.
- Exception count: 3 vectors where the adder flags an exception on vectors 0 and 2 (e.g. 7F800000+FF800000) -> o_res_exc=1,0,1 and o_exc_count=2 at o_done; the next start clears it to 0.
- Edge controls: i_count=0 -> o_busy for 1 cycle, o_done pulse, no o_res_valid. A second i_start mid-run -> no effect and the run length is unchanged.
- Reset mid-run: drop i_rst_n during WAIT of vector 1 -> all outputs 0 immediately, state IDLE, no o_done. A fresh start then reruns from index 0.
